// File: rtl/can_pkg.sv
// Shared types and DLC-to-length mapping for the CAN/CAN-FD transmit path.
package can_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } tx_timer_state_t;

    localparam logic [6:0] CAN_MAX_CLASSIC = 7'd8;
    localparam logic [6:0] CANFD_MAX       = 7'd64;

    // Codes 9-15 are "8 bytes" on classic CAN; FD steps them up to 64 bytes.
    function automatic logic [6:0] dlc_to_len(input logic [3:0] dlc, input logic fd);
        logic [6:0] len;
        if (dlc <= 4'd8) begin
            len = {3'b000, dlc};
        end else if (!fd) begin
            len = CAN_MAX_CLASSIC;
        end else begin
            case (dlc)
                4'd9:    len = 7'd12;
                4'd10:   len = 7'd16;
                4'd11:   len = 7'd20;
                4'd12:   len = 7'd24;
                4'd13:   len = 7'd32;
                4'd14:   len = 7'd48;
                default: len = CANFD_MAX;
            endcase
        end
        return len;
    endfunction

endpackage

// File: rtl/can_tx_payload_timer_dlc.sv
// Combinational DLC decode, clamped to the largest payload this instance supports.
import can_pkg::*;

module can_dlc_decode #(
    parameter int MAX_BYTES = 64,
    parameter int FD_EN     = 1,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic [3:0]       dlc_i,
    input  logic             fd_mode_i,
    output logic [LEN_W-1:0] len_o
);

    logic       fd_eff;
    logic [6:0] raw_len;

    always_comb begin
        fd_eff  = (FD_EN != 0) && fd_mode_i;
        raw_len = dlc_to_len(dlc_i, fd_eff);
        if (int'(raw_len) > MAX_BYTES) begin
            len_o = LEN_W'(MAX_BYTES);
        end else begin
            len_o = LEN_W'(raw_len);
        end
    end

endmodule

// File: rtl/can_tx_payload_timer.sv
// Tracks bit/byte position through the CAN data field on the system clock,
// advancing on counted (non-stuff) bit strobes from the TX bit-timing logic.
import can_pkg::*;

module can_tx_payload_timer #(
    parameter int BYTE_BITS = 8,
    parameter int MAX_BYTES = 64,
    parameter int FD_EN     = 1,
    localparam int BIT_W    = $clog2(BYTE_BITS),
    localparam int BYTE_W   = $clog2(MAX_BYTES),
    localparam int LEN_W    = $clog2(MAX_BYTES + 1)
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              tx_strobe,
    input  logic              dataphase,
    input  logic              bitstuff,
    input  logic              fd_mode,
    input  logic [3:0]        dlc,
    output logic [LEN_W-1:0]  payload_len,
    output logic [BIT_W-1:0]  bit_num,
    output logic [BYTE_W-1:0] byte_num,
    output logic              byte_complete,
    output logic              last_byte,
    output logic              end_data,
    output logic              overrun
);

    tx_timer_state_t   state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic              bc_q, bc_d;
    logic              lb_q, lb_d;
    logic              ed_q, ed_d;
    logic              ov_q, ov_d;
    logic [LEN_W-1:0]  dec_len;
    logic              cnt_strobe;
    logic [LEN_W-1:0]  byte_next;

    can_dlc_decode #(
        .MAX_BYTES (MAX_BYTES),
        .FD_EN     (FD_EN),
        .LEN_W     (LEN_W)
    ) u_dlc_decode (
        .dlc_i     (dlc),
        .fd_mode_i (fd_mode),
        .len_o     (dec_len)
    );

    assign cnt_strobe = tx_strobe & ~bitstuff & dataphase;
    assign byte_next  = LEN_W'(byte_q) + LEN_W'(1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        bc_d    = 1'b0;
        lb_d    = lb_q;
        ed_d    = ed_q;
        ov_d    = 1'b0;

        // Leaving the data field clears everything, even over a same-cycle strobe.
        if (!dataphase) begin
            state_d = IDLE;
            len_d   = '0;
            bit_d   = '0;
            byte_d  = '0;
            lb_d    = 1'b0;
            ed_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    len_d = dec_len;
                    if (dec_len == '0) begin
                        state_d = DONE;
                        ed_d    = 1'b1;
                    end else begin
                        state_d = COUNT;
                        lb_d    = (dec_len == LEN_W'(1));
                        if (cnt_strobe) begin
                            bit_d = BIT_W'(1);
                        end
                    end
                end
                COUNT: begin
                    if (cnt_strobe) begin
                        if (bit_q == BIT_W'(BYTE_BITS - 1)) begin
                            bit_d = '0;
                            bc_d  = 1'b1;
                            if (byte_next < len_q) begin
                                byte_d = byte_q + BYTE_W'(1);
                                lb_d   = (byte_next == len_q - LEN_W'(1));
                            end else begin
                                ed_d    = 1'b1;
                                state_d = DONE;
                            end
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end
                end
                DONE: begin
                    ov_d = cnt_strobe;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            len_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            bc_q    <= 1'b0;
            lb_q    <= 1'b0;
            ed_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            bc_q    <= bc_d;
            lb_q    <= lb_d;
            ed_q    <= ed_d;
            ov_q    <= ov_d;
        end
    end

    assign payload_len   = len_q;
    assign bit_num       = bit_q;
    assign byte_num      = byte_q;
    assign byte_complete = bc_q;
    assign last_byte     = lb_q;
    assign end_data      = ed_q;
    assign overrun       = ov_q;

endmodule

// File: tb/tb_can_tx_payload_timer.sv
// Bench for can_tx_payload_timer: directed scenarios plus random frames against
// a strobe-count reference model; a second instance checks length clamping.
module tb_can_tx_payload_timer;

    localparam int BB = 8;

    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic       tx_strobe = 1'b0;
    logic       dataphase = 1'b0;
    logic       bitstuff = 1'b0;
    logic       fd_mode = 1'b0;
    logic [3:0] dlc = 4'd0;

    logic [6:0] payload_len;
    logic [2:0] bit_num;
    logic [5:0] byte_num;
    logic       byte_complete, last_byte, end_data, overrun;

    logic [4:0] payload_len2;
    logic [2:0] bit_num2;
    logic [3:0] byte_num2;
    logic       byte_complete2, last_byte2, end_data2, overrun2;

    int checks = 0;
    int errors = 0;

    // Reference model state: strobes counted in the current frame and its length.
    bit m_active = 0;
    int m_n      = 0;
    int m_len    = 0;
    int m_len2   = 0;
    bit m_bc     = 0;
    bit m_ov     = 0;

    can_tx_payload_timer #(.BYTE_BITS(8), .MAX_BYTES(64), .FD_EN(1)) dut (
        .clk(clk), .nRST(nRST), .tx_strobe(tx_strobe), .dataphase(dataphase),
        .bitstuff(bitstuff), .fd_mode(fd_mode), .dlc(dlc),
        .payload_len(payload_len), .bit_num(bit_num), .byte_num(byte_num),
        .byte_complete(byte_complete), .last_byte(last_byte),
        .end_data(end_data), .overrun(overrun)
    );

    can_tx_payload_timer #(.BYTE_BITS(8), .MAX_BYTES(16), .FD_EN(1)) dut16 (
        .clk(clk), .nRST(nRST), .tx_strobe(tx_strobe), .dataphase(dataphase),
        .bitstuff(bitstuff), .fd_mode(fd_mode), .dlc(dlc),
        .payload_len(payload_len2), .bit_num(bit_num2), .byte_num(byte_num2),
        .byte_complete(byte_complete2), .last_byte(last_byte2),
        .end_data(end_data2), .overrun(overrun2)
    );

    always #5 clk = ~clk;

    function automatic int ref_len(input int code, input bit fd, input int max_bytes);
        int fd_tab[7] = '{12, 16, 20, 24, 32, 48, 64};
        int l;
        if (code <= 8)   l = code;
        else if (!fd)    l = 8;
        else             l = fd_tab[code - 9];
        return (l > max_bytes) ? max_bytes : l;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int exp_byte;
        bit done;
        done     = m_active && (m_n >= m_len * BB);
        exp_byte = (m_len == 0) ? 0 : ((m_n / BB < m_len) ? m_n / BB : m_len - 1);
        chk("payload_len", 32'(payload_len), 32'(m_len));
        chk("payload_len_clamp16", 32'(payload_len2), 32'(m_len2));
        chk("bit_num", 32'(bit_num), 32'(m_n % BB));
        chk("byte_num", 32'(byte_num), 32'(exp_byte));
        chk("byte_complete", 32'(byte_complete), 32'(m_bc));
        chk("last_byte", 32'(last_byte), 32'(m_active && m_len > 0 && exp_byte == m_len - 1));
        chk("end_data", 32'(end_data), 32'(done));
        chk("overrun", 32'(overrun), 32'(m_ov));
    endtask

    task automatic model_update();
        bit cs;
        cs   = tx_strobe && !bitstuff && dataphase;
        m_bc = 0;
        m_ov = 0;
        if (!dataphase) begin
            m_active = 0;
            m_n      = 0;
            m_len    = 0;
            m_len2   = 0;
        end else if (!m_active) begin
            m_active = 1;
            m_len    = ref_len(int'(dlc), fd_mode, 64);
            m_len2   = ref_len(int'(dlc), fd_mode, 16);
            m_n      = (m_len > 0 && cs) ? 1 : 0;
        end else if (cs) begin
            if (m_n >= m_len * BB) begin
                m_ov = 1;
            end else begin
                m_n++;
                m_bc = (m_n % BB == 0);
            end
        end
    endtask

    task automatic step(input bit dp, input bit st, input bit sf);
        dataphase = dp;
        tx_strobe = st;
        bitstuff  = sf;
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic model_reset();
        m_active = 0;
        m_n      = 0;
        m_len    = 0;
        m_len2   = 0;
        m_bc     = 0;
        m_ov     = 0;
    endtask

    initial begin
        int tot_bc;
        int lim;
        bit st, sf;

        // Reset state.
        #12;
        check_all();
        @(posedge clk);
        #1 nRST = 1'b1;

        // Classic dlc=2: entry, 16 strobes, one overrun strobe, idle, exit.
        dlc = 4'd2; fd_mode = 1'b0;
        step(1, 0, 0);
        tot_bc = 0;
        for (int i = 0; i < 17; i++) begin
            step(1, 1, 0);
            if (byte_complete) tot_bc++;
        end
        step(1, 0, 0);
        chk("classic_bc_count", 32'(tot_bc), 32'd2);
        step(0, 0, 0);

        // Stuff skip, dlc=1: stuff on strobes 3 and 6.
        dlc = 4'd1;
        step(1, 0, 0);
        for (int i = 1; i <= 10; i++) step(1, 1, (i == 3 || i == 6));
        step(0, 0, 0);

        // FD dlc=15 with same-cycle entry strobe: 512 counted strobes.
        dlc = 4'd15; fd_mode = 1'b1;
        tot_bc = 0;
        step(1, 1, 0);
        for (int i = 1; i < 512; i++) begin
            step(1, 1, 0);
            if (byte_complete) tot_bc++;
        end
        chk("fd64_bc_count", 32'(tot_bc), 32'd64);
        chk("fd64_last_byte_idx", 32'(byte_num), 32'd63);
        step(0, 0, 0);

        // Classic mapping of dlc=12, and FD dlc=13 (clamped to 16 on dut16).
        dlc = 4'd12; fd_mode = 1'b0;
        step(1, 0, 0);
        for (int i = 0; i < 65; i++) step(1, 1, 0);
        step(0, 0, 0);
        dlc = 4'd13; fd_mode = 1'b1;
        step(1, 0, 0);
        step(0, 0, 0);

        // Zero-length frame, then dlc change mid-frame is ignored.
        dlc = 4'd0;
        step(1, 0, 0);
        step(1, 1, 0);
        step(0, 0, 0);
        dlc = 4'd2; fd_mode = 1'b0;
        step(1, 0, 0);
        dlc = 4'd5;
        for (int i = 0; i < 18; i++) step(1, 1, 0);
        step(0, 0, 0);

        // Abort at bit 5 of byte 1 with a coincident strobe.
        dlc = 4'd2;
        step(1, 0, 0);
        for (int i = 0; i < 13; i++) step(1, 1, 0);
        step(0, 1, 0);
        step(0, 0, 0);

        // Async reset mid-count: outputs clear before the next edge.
        dlc = 4'd3;
        step(1, 0, 0);
        for (int i = 0; i < 11; i++) step(1, 1, 0);
        #2 nRST = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        nRST = 1'b1;
        step(0, 0, 0);

        // Random frames with stuff bits, gaps, mid-frame dlc noise and early aborts.
        for (int f = 0; f < 24; f++) begin
            dlc     = 4'($urandom_range(0, 15));
            fd_mode = 1'($urandom_range(0, 1));
            step(1, 1'($urandom_range(0, 1)), 1'b0);
            lim = ref_len(int'(dlc), fd_mode, 64) * BB * 2 + 6;
            for (int i = 0; i < lim; i++) begin
                if ($urandom_range(0, 299) == 0) break;
                if ($urandom_range(0, 19) == 0) begin
                    dlc     = 4'($urandom_range(0, 15));
                    fd_mode = 1'($urandom_range(0, 1));
                end
                st = ($urandom_range(0, 9) < 7);
                sf = ($urandom_range(0, 9) < 2);
                step(1, st, sf);
            end
            step(0, 1'($urandom_range(0, 1)), 1'b0);
            step(0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/can_tx_payload_timer.md
Name: can_tx_payload_timer

Overview:
Parametrised CAN/CAN-FD transmit payload timer. It tracks the bit position within each payload byte and the byte index within the data field. The count advances on single-cycle bit strobes from the TX bit-timing logic and skips stuff bits. It flags byte boundaries, the last byte and end of the data field to the TX shift/CRC logic in wb_CAN, running on the system clock instead of clocking counters from strobes.

Parameters:
BYTE_BITS, 8, bits per payload byte (>=2)
MAX_BYTES, 64, largest payload supported; decoded lengths above this clamp to MAX_BYTES
FD_EN, 1, 1 = honour fd_mode DLC mapping; 0 = classic only, fd_mode ignored
(derived, localparam) BIT_W = $clog2(BYTE_BITS), BYTE_W = $clog2(MAX_BYTES), LEN_W = $clog2(MAX_BYTES+1)

Ports:
clk  input  1  system clock
nRST  input  1  asynchronous active-low reset
tx_strobe  input  1  one-cycle pulse per transmitted bit time
dataphase  input  1  level, high while the data field is being sent
bitstuff  input  1  qualifies tx_strobe: current bit is a stuff bit, not counted
fd_mode  input  1  1 = FD DLC mapping
dlc  input  4  data length code, sampled on dataphase entry
payload_len  output  LEN_W  latched decoded byte count
bit_num  output  BIT_W  bit index within current byte
byte_num  output  BYTE_W  index of byte currently sent
byte_complete  output  1  one-cycle pulse, byte finished
last_byte  output  1  level, byte_num == payload_len-1 while counting
end_data  output  1  level, data field finished; held until dataphase low
overrun  output  1  one-cycle pulse, counted strobe arrived in DONE

Behaviour:
- Reset (async, nRST low): state IDLE; all outputs 0.
- All outputs are registered. "Counted strobe" = tx_strobe & ~bitstuff & dataphase.
- DLC decode:
  - dlc 0-8 -> dlc.
  - Classic (fd_mode=0 or FD_EN=0): dlc 9-15 -> 8.
  - FD: 9->12, 10->16, 11->20, 12->24, 13->32, 14->48, 15->64.
  - Result clamped to MAX_BYTES.
- IDLE:
  - dataphase low: counters held 0, outputs 0.
  - dataphase high: latch payload_len from dlc/fd_mode.
    - len==0 -> go to DONE; end_data=1 on the next edge; no byte_complete.
    - Otherwise go to COUNT. A counted strobe in this same cycle is counted as bit 0, using the newly latched length.
- COUNT, on each counted strobe:
  - If bit_num < BYTE_BITS-1: bit_num++.
  - If bit_num == BYTE_BITS-1:
    - bit_num -> 0 and byte_complete pulses on the same edge.
    - If byte_num < len-1: byte_num++.
    - Else: byte_num holds at len-1, end_data=1, state -> DONE.
  - Stuff strobes (bitstuff=1) change nothing.
- DONE: counters frozen; end_data stays 1. A counted strobe pulses overrun for one cycle.
- dataphase low in any state: next edge returns to IDLE and clears bit_num, byte_num, end_data, last_byte and payload_len. Clear wins over a simultaneous strobe.
- Changes to dlc/fd_mode while in COUNT or DONE are ignored.
- last_byte is combinational-equivalent but registered. It is high from the edge byte_num reaches len-1 until exit to IDLE, and stays high in DONE.

Decomposition:
- Package can_pkg:
  - tx_timer_state_t enum {IDLE, COUNT, DONE}.
  - Function dlc_to_len(dlc, fd) returning 7-bit length.
  - Constants CAN_MAX_CLASSIC = 8 and CANFD_MAX = 64.
- One natural sub-module: can_dlc_decode, a small combinational wrapper around dlc_to_len that applies clamping to MAX_BYTES.
- Counters are inline with enables, not strobe-clocked.

Test Plan:
- Classic, dlc=2: 16 counted strobes -> byte_complete pulses after strobes 8 and 16; byte_num 0->1; last_byte high from strobe 8; end_data high after strobe 16; a 17th strobe -> overrun pulse.
- Stuff skip, dlc=1: 8 strobes with bitstuff=1 on strobes 3 and 6 (10 total) -> byte_complete only after the 10th strobe; bit_num never advances on stuff strobes.
- FD, dlc=15, MAX_BYTES=64: 512 counted strobes -> 64 byte_complete pulses; byte_num ends at 63; end_data set.
- FD_EN=0 or fd_mode=0, dlc=12 -> payload_len=8; end_data after 64 strobes. MAX_BYTES=16 with FD dlc=13 -> payload_len clamped to 16.
- dlc=0, dataphase rises -> end_data=1 one cycle later; no byte_complete. dlc changed mid-frame (2->5) -> still ends after 16 strobes.
- Abort: dataphase falls at bit 5 of byte 1, coincident with a strobe -> all counters 0 next cycle; no byte_complete. Async nRST pulse mid-COUNT -> all outputs 0 immediately.
